chunked_add_sequencer: RTL
==========================

CHUNKED_ADD_SEQUENCER -- requirements
Module: chunked_add_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameters SHALL be:
- WIDTH, default 32: operand width in bits.
- CHUNK, default 4: bits added per cycle. WIDTH SHALL be an integer multiple of CHUNK.
REQ-003 Ports SHALL be, clock and reset first:
- iClk  in  1  clock; all state updates on its rising edge.
- iRst  in  1  asynchronous active-high reset.
- iValid  in  1  operand request.
- oReady  out  1  block can accept a request.
- iA  in  WIDTH  operand A.
- iB  in  WIDTH  operand B.
- iCarryIn  in  1  carry into bit 0.
- oValid  out  1  result available.
- iReady  in  1  consumer accepts the result.
- oSum  out  WIDTH  A+B+cin, low WIDTH bits.
- oCarryOut  out  1  carry out of bit WIDTH-1.
- oBusy  out  1  block is in RUN.

Function
REQ-004 The FSM SHALL have three states, IDLE, RUN and DONE, with these transitions:
- IDLE->RUN on iValid&oReady.
- RUN->DONE after the last chunk.
- DONE->IDLE on oValid&iReady.
REQ-005 oReady SHALL be 1 only in IDLE. oBusy SHALL be 1 only in RUN. oValid SHALL be 1 only in DONE.
REQ-006 On accept, the block SHALL latch iA, iB and iCarryIn into internal registers, set the running carry to iCarryIn and set the chunk index to 0.
REQ-007 Each RUN cycle SHALL process chunk k (bits k*CHUNK .. k*CHUNK+CHUNK-1) as follows:
- Per bit: g=a&b, p=a|b, s=a^b^c.
- Ripple within the chunk: c[i+1]=g[i]|(p[i]&c[i]).
- Write the sum bits into result bits of chunk k.
- Register the chunk carry-out as the running carry.
- Increment k.
REQ-008 RUN SHALL last exactly WIDTH/CHUNK cycles. oValid SHALL rise on the edge WIDTH/CHUNK cycles after the accept edge (8 cycles at default parameters).
REQ-009 On the last chunk, the final carry SHALL be registered to oCarryOut. oSum and oCarryOut SHALL be registered outputs that are stable throughout DONE.
REQ-010 While oValid=1 and iReady=0, oSum, oCarryOut and oValid SHALL hold unchanged indefinitely.
REQ-011 iValid, iA, iB and iCarryIn SHALL be ignored outside IDLE; latched operands SHALL NOT change during RUN or DONE.
REQ-012 The result SHALL equal (iA+iB+iCarryIn) mod 2^(WIDTH+1), split as {oCarryOut,oSum}, for all inputs including all-ones operands and cin=1.
REQ-013 After a DONE handshake the block SHALL be in IDLE with oReady=1 on the next cycle; at most one request SHALL be accepted every WIDTH/CHUNK+2 cycles.

Reset
REQ-014 Asserting iRst SHALL immediately force the following, independent of iClk:
- state=IDLE
- oReady=1
- oValid=0
- oBusy=0
- oSum=0
- oCarryOut=0
- chunk index=0
- running carry=0
REQ-015 Reset during RUN or DONE SHALL discard the in-flight operation; no oValid SHALL follow for it.
REQ-016 After iRst deasserts, the block SHALL accept a new request on the first rising edge with iValid=1.

Configuration
REQ-017 When macro CHUNKED_ADD_OVERFLOW_EN is defined:
- A port oOverflow (out, 1 bit) SHALL exist, registered alongside oSum.
- It SHALL be 1 when A[MSB]==B[MSB] and Sum[MSB]!=A[MSB] (signed overflow).
- It SHALL reset to 0 and hold under backpressure as oSum does.
REQ-018 When CHUNKED_ADD_OVERFLOW_EN is undefined, oOverflow and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (WIDTH=32, CHUNK=4)
REQ-019 Full carry ripple: A=0xFFFFFFFF, B=0x00000001, cin=0 -> oSum=0x00000000, oCarryOut=1, oValid rises exactly 8 cycles after accept.
REQ-020 Carry-in: A=0x12345678, B=0x11111111, cin=1 -> oSum=0x2345678A, oCarryOut=0.
REQ-021 Backpressure: hold iReady=0 for 5 cycles in DONE and pulse iValid with new operands -> oSum, oCarryOut and oValid stay constant, oReady=0, new operands ignored; on iReady=1 the block returns to IDLE next cycle.
REQ-022 Reset mid-RUN: assert iRst after 4 RUN cycles -> all outputs return to reset values immediately, no oValid for that operation, and a fresh request A=3, B=4 yields oSum=7.
REQ-023 Overflow with macro defined: A=0x7FFFFFFF, B=0x00000001 -> oSum=0x80000000, oOverflow=1, oCarryOut=0; A=0xFFFFFFFF, B=0xFFFFFFFF -> oOverflow=0, oCarryOut=1.
REQ-024 Back-to-back with iValid and iReady held at 1: three requests -> accepts spaced exactly 10 cycles apart, and each result matches its reference model.

Source files
------------

// File: rtl/chunked_add_sequencer.sv
// Multi-cycle adder: sums two WIDTH-bit operands CHUNK bits per cycle with a registered ripple carry.
// Optional signed-overflow flag oOverflow is built when CHUNKED_ADD_OVERFLOW_EN is defined.
module chunked_add_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 4
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iCarryIn,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oSum,
  output logic             oCarryOut,
  output logic             oBusy
`ifdef CHUNKED_ADD_OVERFLOW_EN
  ,
  output logic             oOverflow
`endif
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_next;
  logic [WIDTH-1:0]  a_q, b_q;
  logic              carry_q;
  logic [IDXW-1:0]   idx_q;
  logic              last_chunk;
  int unsigned       base;
  logic [CHUNK-1:0]  a_chunk, b_chunk, g, p, chunk_sum;
  logic [CHUNK:0]    c;
  logic [WIDTH-1:0]  chunk_mask, sum_next;

  // State register
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (iValid)     state_next = RUN;
      RUN:     if (last_chunk) state_next = DONE;
      DONE:    if (iReady)     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake/status outputs decoded purely from state
  always_comb begin
    oReady = (state == IDLE);
    oBusy  = (state == RUN);
    oValid = (state == DONE);
  end

  // Chunk k adder: generate/propagate ripple seeded by the running carry
  always_comb begin
    last_chunk = (idx_q == IDXW'(NCHUNK - 1));
    base       = 32'(idx_q) * CHUNK;
    a_chunk    = CHUNK'(a_q >> base);
    b_chunk    = CHUNK'(b_q >> base);
    g          = a_chunk & b_chunk;
    p          = a_chunk | b_chunk;
    c          = '0;
    c[0]       = carry_q;
    chunk_sum  = '0;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      chunk_sum[i] = a_chunk[i] ^ b_chunk[i] ^ c[i];
      c[i+1]       = g[i] | (p[i] & c[i]);
    end
    chunk_mask = WIDTH'({CHUNK{1'b1}}) << base;
    sum_next   = (oSum & ~chunk_mask) | ((WIDTH'(chunk_sum) << base) & chunk_mask);
  end

  // Datapath: operands latched only on accept, result built chunk by chunk in oSum
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      oSum      <= '0;
      oCarryOut <= 1'b0;
`ifdef CHUNKED_ADD_OVERFLOW_EN
      oOverflow <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (iValid) begin
            a_q     <= iA;
            b_q     <= iB;
            carry_q <= iCarryIn;
            idx_q   <= '0;
          end
        end
        RUN: begin
          oSum    <= sum_next;
          carry_q <= c[CHUNK];
          if (last_chunk) begin
            idx_q     <= '0;
            oCarryOut <= c[CHUNK];
`ifdef CHUNKED_ADD_OVERFLOW_EN
            oOverflow <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                         (chunk_sum[CHUNK-1] != a_q[WIDTH-1]);
`endif
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
